// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and fills the IF/ID register, honouring stalls and EX-stage redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
  output logic [31:0] ifid_pc4
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic        ack_ok;
  logic [31:0] addr_inc;
  logic [31:0] target;

  always_comb begin
    ack_ok   = imem_ack & imem_req_q;
    addr_inc = imem_addr_q + 32'd4;
    target   = branch_target & ~32'd3;

    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    discard_d    = discard_q;
    hold_instr_d = hold_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;

    if (branch_taken) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      pc_d         = target;
      state_d      = FETCH;
      if (state_q == FETCH && imem_req_q && !ack_ok) begin
        // Memory still owes us a word for the old path; swallow it when it lands.
        discard_d = 1'b1;
      end else begin
        discard_d   = 1'b0;
        imem_req_d  = 1'b1;
        imem_addr_d = target;
      end
    end else if (discard_q) begin
      if (ack_ok) begin
        discard_d   = 1'b0;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
      end
    end else if (state_q == HOLD) begin
      if (!stall) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = hold_instr_q;
        ifid_pc4_d   = addr_inc;
        imem_req_d   = 1'b1;
        imem_addr_d  = addr_inc;
        state_d      = FETCH;
      end
    end else if (!imem_req_q) begin
      // Idle after reset: launch the first request from the PC.
      imem_req_d  = 1'b1;
      imem_addr_d = pc_q;
      if (!stall) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end else if (ack_ok && !stall) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = addr_inc;
      pc_d         = addr_inc;
      imem_addr_d  = addr_inc;
    end else if (ack_ok) begin
      hold_instr_d = imem_rdata;
      imem_req_d   = 1'b0;
      pc_d         = addr_inc;
      state_d      = HOLD;
    end else if (!stall) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      discard_q    <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_opcode = ifid_instr_q[31:26];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Cycle-by-cycle vector bench for if_fetch_stage: each record gives this
// cycle's inputs and the registered outputs expected during that cycle.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [31:0] ifid_pc4;

  if_fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_opcode(ifid_opcode), .ifid_pc4(ifid_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        stall, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, pc4;
  } vec_t;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, pc4;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vectors = 0;
  int   n_checks = 0;
  int   n_miscompares = 0;

  function automatic void v(input logic r, input logic a, input logic [31:0] d,
                            input logic s, input logic b, input logic [31:0] t,
                            input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4);
    vec_t x;
    x.rst = r; x.ack = a; x.rdata = d; x.stall = s; x.br = b; x.tgt = t;
    x.req = e_req; x.addr = e_addr; x.valid = e_valid; x.instr = e_instr; x.pc4 = e_pc4;
    vecs.push_back(x);
  endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, req);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    //   rst ack rdata          stl br  tgt            req addr           vld instr          pc4
    v(1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'h8C01_0004,  0, 0, 32'h0,           0, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'h8C01_0004,  0, 0, 32'h0,           1, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'h0022_1820,  0, 0, 32'h0,           1, 32'h4,          1, 32'h8C01_0004,  32'h4);
    // three-cycle ack latency on address 8
    v(0, 0, 32'h0,          0, 0, 32'h0,           1, 32'h8,          1, 32'h0022_1820,  32'h8);
    v(0, 0, 32'h0,          0, 0, 32'h0,           1, 32'h8,          0, 32'h0,          32'h8);
    v(0, 1, 32'hAC43_0000,  0, 0, 32'h0,           1, 32'h8,          0, 32'h0,          32'h8);
    // stall on the ack cycle, two cycles long
    v(0, 1, 32'h2002_0005,  1, 0, 32'h0,           1, 32'hC,          1, 32'hAC43_0000,  32'hC);
    v(0, 0, 32'h0,          1, 0, 32'h0,           0, 32'hC,          1, 32'hAC43_0000,  32'hC);
    v(0, 0, 32'h0,          0, 0, 32'h0,           0, 32'hC,          1, 32'hAC43_0000,  32'hC);
    // redirect while 0x10 is outstanding: 0x10 held, its data dropped, then 0x40
    v(0, 0, 32'h0,          0, 1, 32'h0000_0043,   1, 32'h10,         1, 32'h2002_0005,  32'h10);
    v(0, 0, 32'h0,          0, 0, 32'h0,           1, 32'h10,         0, 32'h0,          32'h10);
    v(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,           1, 32'h10,         0, 32'h0,          32'h10);
    v(0, 1, 32'h8C22_0008,  0, 0, 32'h0,           1, 32'h40,         0, 32'h0,          32'h10);
    // redirect + stall with ack, then redirect while in HOLD
    v(0, 1, 32'h1111_1111,  1, 1, 32'h0000_0100,   1, 32'h44,         1, 32'h8C22_0008,  32'h44);
    v(0, 1, 32'h2003_0001,  1, 0, 32'h0,           1, 32'h100,        0, 32'h0,          32'h44);
    v(0, 0, 32'h0,          1, 1, 32'h0000_0200,   0, 32'h100,        0, 32'h0,          32'h44);
    v(0, 1, 32'h2404_0002,  0, 0, 32'h0,           1, 32'h200,        0, 32'h0,          32'h44);
    v(0, 0, 32'h0,          0, 0, 32'h0,           1, 32'h204,        1, 32'h2404_0002,  32'h204);
    // asynchronous reset while 0x204 is pending
    v(1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'h5555_5555,  0, 0, 32'h0,           0, 32'h0,          0, 32'h0,          32'h0);
    // double redirect while pending, newest target wins; then wrap past 0xFFFF_FFFC
    v(0, 0, 32'h0,          0, 1, 32'h0000_0080,   1, 32'h0,          0, 32'h0,          32'h0);
    v(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFF,   1, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'hBAD0_BAD0,  0, 0, 32'h0,           1, 32'h0,          0, 32'h0,          32'h0);
    v(0, 1, 32'h0000_0020,  0, 0, 32'h0,           1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0);
    v(0, 1, 32'h8C01_0004,  0, 0, 32'h0,           1, 32'h0,          1, 32'h0000_0020,  32'h0);
    v(0, 0, 32'h0,          0, 0, 32'h0,           1, 32'h4,          1, 32'h8C01_0004,  32'h4);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      rst = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      e.idx = i; e.req = vecs[i].req; e.addr = vecs[i].addr;
      e.valid = vecs[i].valid; e.instr = vecs[i].instr; e.pc4 = vecs[i].pc4;
      sb.push_back(e);
      n_vectors++;
      @(negedge clk);
      got = sb.pop_front();
      chk(got.idx, "imem_req",    {31'h0, imem_req},   {31'h0, got.req});
      chk(got.idx, "imem_addr",   imem_addr,           got.addr);
      chk(got.idx, "ifid_valid",  {31'h0, ifid_valid}, {31'h0, got.valid});
      chk(got.idx, "ifid_instr",  ifid_instr,          got.instr);
      chk(got.idx, "ifid_pc4",    ifid_pc4,            got.pc4);
      chk(got.idx, "ifid_opcode", {26'h0, ifid_opcode}, {26'h0, got.instr[31:26]});
      $display("vec%0d rst=%0b ack=%0b stall=%0b br=%0b -> req=%0b addr=%h valid=%0b instr=%h pc4=%h",
               i, vecs[i].rst, vecs[i].ack, vecs[i].stall, vecs[i].br,
               imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4);
    end

    if (sb.size() != 0) begin
      n_miscompares++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage: owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers each returned word into the IF/ID pipeline register. ifid_opcode drives the control unit's opcode input in ID.
- Handles hazard-unit stalls and EX-stage branch redirects, including discarding an in-flight fetch that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0000, word loaded into ifid_instr on bubble/flush.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch word address, registered, bits [1:0] always 0
imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_ack=1
stall  input  1  hazard unit: hold IF/ID and PC
branch_taken  input  1  EX redirect strobe, one cycle
branch_target  input  32  redirect address, bits [1:0] ignored (forced 00)
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  32  IF/ID instruction word
ifid_opcode  output  6  ifid_instr[31:26], to control_unit
ifid_pc4  output  32  fetch address + 4 of ifid_instr

Behaviour:
- Reset (async, any time including mid-transaction): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, discard=0, state=FETCH.
  - An outstanding memory transaction is abandoned.
  - First edge after rst falls sets imem_req=1 with imem_addr=pc.
- Internal state: pc (next address to fetch), discard flag, hold_instr buffer, FSM {FETCH, HOLD}.
- Handshake: once imem_req=1, imem_addr is frozen until the cycle imem_ack=1.
  - Variable latency; ack may arrive in the first request cycle.
  - Address and PC are separate registers so a redirect never disturbs an outstanding address.
- Priority: rst > branch_taken > stall > normal.
- FETCH, ack=1, discard=0, no redirect, stall=0:
  - ifid_instr<=imem_rdata, ifid_pc4<=imem_addr+4, ifid_valid<=1.
  - pc<=imem_addr+4; next imem_addr=imem_addr+4, req stays 1 (back-to-back fetch, one instruction/cycle).
- FETCH, ack=0, stall=0: bubble: ifid_valid<=0, ifid_instr<=NOP_INSTR; request continues unchanged.
- FETCH, ack=1, stall=1: hold_instr<=imem_rdata, imem_req<=0, state->HOLD; IF/ID unchanged.
- FETCH, ack=0, stall=1: IF/ID unchanged, request continues.
- HOLD, stall=1: everything held, imem_req=0.
- HOLD, stall=0: IF/ID<=hold_instr (valid=1, pc4=imem_addr+4); imem_req<=1, imem_addr<=imem_addr+4; state->FETCH.
- branch_taken=1 (any state, overrides stall):
  - IF/ID flushed (valid=0, instr=NOP_INSTR); pc<=target & ~3.
  - FETCH with ack=1 same cycle: data dropped; next cycle imem_addr=target, req=1.
  - FETCH with ack=0: discard<=1, address held. On the later ack, data is dropped, discard<=0, next cycle imem_addr=pc (target).
  - Second redirect while discard=1: pc updated to the newest target, discard stays 1.
  - HOLD: hold_instr dropped, state->FETCH, next imem_addr=target, req=1.
- While discard=1, no instruction is written to IF/ID regardless of stall.
- Arithmetic: all address adds are modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
- ifid_opcode is combinational from ifid_instr.

Test Plan:
- Reset release, ack tied 1 with rdata=8C01_0004 then 0022_1820 -> imem_addr 0,4,8; ifid_instr follows one cycle later; ifid_pc4=4,8; ifid_opcode=6'b100011 then 6'b000000.
- Ack latency 3 cycles -> imem_addr stable during wait; ifid_valid=0 with instr=0 for 2 bubble cycles per word.
- Stall asserted on ack cycle for 2 cycles, rdata=2002_0005 -> imem_req=0 during stall; word appears in IF/ID at stall release with correct pc4; next address +4; no word lost or duplicated.
- branch_taken with target 0x0000_0043 while request at 0x10 pending (ack 2 cycles later) -> IF/ID flushed; addr 0x10 held until ack; its data discarded; next request at 0x40.
- branch_taken and stall same cycle, plus redirect in HOLD -> flush wins; buffered word dropped; fetch resumes at target.
- rst pulsed while request pending, and PC at 0xFFFF_FFFC -> reset values restored immediately; separately confirm wrap to address 0 with ifid_pc4=0.
